peripheral_spram_wb_master: RTL and testbench

Command-driven Wishbone burst master that sits directly upstream of the Wishbone single-port RAM slave (`peripheral_spram_wb`) and drives its bus. It accepts one transfer command at a time: word address, beat count, direction and byte lanes. Write beats are sourced from a valid/ready data stream. Read data is returned on a 2-entry buffered valid/ready stream, with linear incrementing bursts issued on the bus.

---
 rtl/peripheral_spram_wb_master_if.sv | 28 ++
 rtl/peripheral_spram_wb_master.sv | 196 +++++++++++++++++++
 tb/tb_peripheral_spram_wb_master.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_spram_wb_master_if.sv
// Wishbone bus between the burst master and the single-port RAM slave.
// dat_w carries master-to-slave write data, dat_r carries slave-to-master read data.
interface peripheral_spram_wb_master_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic [3:0]    sel;
  logic          we;
  logic [1:0]    bte;
  logic [2:0]    cti;
  logic          cyc;
  logic          stb;
  logic          ack;
  logic          err;

  modport master (
    output adr, dat_w, sel, we, bte, cti, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, bte, cti, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/peripheral_spram_wb_master.sv
// Command-driven Wishbone burst master with streamed write data and a 2-entry read buffer.
// Define PERIPHERAL_SPRAM_WB_MASTER_BURST_EN for incrementing bursts with cyc held per command.
module peripheral_spram_wb_master #(
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int MAXLEN = 16,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic [3:0]    cmd_sel_i,
  input  logic          wdat_valid_i,
  output logic          wdat_ready_o,
  input  logic [DW-1:0] wdat_i,
  output logic          rdat_valid_o,
  input  logic          rdat_ready_i,
  output logic [DW-1:0] rdat_o,
  output logic          rdat_last_o,
  output logic          done_o,
  output logic          done_err_o,
  peripheral_spram_wb_master_if.master wb
);

  typedef enum logic [1:0] {IDLE, ISSUE, BEAT, DONE} state_e;

  localparam logic [LW-1:0] MaxLen = LW'(MAXLEN);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [3:0]    sel_q, sel_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          err_q, err_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic [2:0]    cti_q, cti_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [DW:0]   buf_q [2];
  logic [DW:0]   buf_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;

  logic          push, pop, can_start;
  logic [2:0]    start_cti;
  logic [LW-1:0] len_clamped;

  // Read buffer entries hold {last, data}
  always_comb begin
    push     = (state_q == BEAT) && wb.ack && !wb.err && !we_q;
    pop      = rdat_ready_i && (cnt_q != 2'd0);
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    buf_d    = buf_q;
    if (push) buf_d[wr_ptr_q] = {rem_q == LW'(1), wb.dat_r};
  end

  // Buffer occupancy after this cycle's push/pop already counts the beat just acked
  assign can_start   = we_q ? wdat_valid_i : (cnt_d < 2'd2);
  assign len_clamped = (cmd_len_i > MaxLen) ? MaxLen : cmd_len_i;

`ifdef PERIPHERAL_SPRAM_WB_MASTER_BURST_EN
  logic next_is_last;
  assign next_is_last = (state_q == BEAT) ? (rem_q == LW'(2)) : (rem_q == LW'(1));
  assign start_cti    = next_is_last ? 3'b111 : 3'b010;
`else
  assign start_cti = 3'b000;
`endif

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    rem_d        = rem_q;
    err_d        = err_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    cti_d        = cti_q;
    dat_d        = dat_q;
    wdat_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          sel_d   = cmd_sel_i;
          rem_d   = len_clamped;
          err_d   = 1'b0;
          state_d = (len_clamped == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (can_start) begin
          wdat_ready_o = we_q;
          if (we_q) dat_d = wdat_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cti_d   = start_cti;
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (wb.err) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (wb.ack) begin
          adr_d = adr_q + AW'(1);
          rem_d = rem_q - LW'(1);
          if (rem_q == LW'(1)) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = DONE;
          end
`ifdef PERIPHERAL_SPRAM_WB_MASTER_BURST_EN
          else if (can_start) begin
            wdat_ready_o = we_q;
            if (we_q) dat_d = wdat_i;
            cti_d = start_cti;
          end else begin
            stb_d   = 1'b0;
            state_d = ISSUE;
          end
`else
          else begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = ISSUE;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      cti_q    <= '0;
      dat_q    <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      cti_q    <= cti_d;
      dat_q    <= dat_d;
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cmd_ready_o             = (state_q == IDLE);
  assign done_o                  = (state_q == DONE);
  assign done_err_o              = (state_q == DONE) && err_q;
  assign rdat_valid_o            = (cnt_q != 2'd0);
  assign {rdat_last_o, rdat_o}   = buf_q[rd_ptr_q];

  assign wb.adr   = adr_q;
  assign wb.dat_w = dat_q;
  assign wb.sel   = sel_q;
  assign wb.we    = we_q;
  assign wb.bte   = 2'b00;
  assign wb.cti   = cti_q;
  assign wb.cyc   = cyc_q;
  assign wb.stb   = stb_q;

endmodule

// File: tb/tb_peripheral_spram_wb_master.sv
// Directed + randomized bench for peripheral_spram_wb_master with a RAM slave model
// and a command-level reference memory.
module tb_peripheral_spram_wb_master;
  localparam int AW     = 8;
  localparam int DW     = 32;
  localparam int MAXLEN = 16;
  localparam int LW     = $clog2(MAXLEN + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_we = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_adr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [3:0]    cmd_sel = '0;
  logic          wdat_valid = 1'b0, wdat_ready;
  logic [DW-1:0] wdat = '0;
  logic          rdat_valid, rdat_ready = 1'b0, rdat_last;
  logic [DW-1:0] rdat;
  logic          done, done_err;

  always #5 clk = ~clk;

  peripheral_spram_wb_master_if #(.AW(AW), .DW(DW)) wb ();

  peripheral_spram_wb_master #(.AW(AW), .DW(DW), .MAXLEN(MAXLEN)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .cmd_sel_i(cmd_sel),
    .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready), .wdat_i(wdat),
    .rdat_valid_o(rdat_valid), .rdat_ready_i(rdat_ready), .rdat_o(rdat), .rdat_last_o(rdat_last),
    .done_o(done), .done_err_o(done_err), .wb(wb.master)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'hC0DE_0000 | DW'(a);
  endfunction

  // Slave: acks one cycle after sampling stb; err_at selects an absolute beat to fail
  logic [DW-1:0] smem [256];
  logic          smem_init = 1'b0;
  int            slv_beats = 0;
  int            err_at = -1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.ack   <= 1'b0;
      wb.err   <= 1'b0;
      wb.dat_r <= '0;
      if (!smem_init) begin
        for (int i = 0; i < 256; i++) smem[i] <= init_word(i);
        smem_init <= 1'b1;
      end
    end else begin
      wb.ack <= 1'b0;
      wb.err <= 1'b0;
      if (wb.cyc && wb.stb && !wb.ack && !wb.err) begin
        if (slv_beats == err_at) wb.err <= 1'b1;
        else begin
          wb.ack <= 1'b1;
          if (wb.we)
            for (int b = 0; b < 4; b++)
              if (wb.sel[b]) smem[wb.adr][8*b +: 8] <= wb.dat_w[8*b +: 8];
          wb.dat_r <= smem[wb.adr];
        end
        slv_beats <= slv_beats + 1;
      end
    end
  end

  typedef struct {logic [AW-1:0] adr; logic [2:0] cti; logic err;} beat_t;
  beat_t         beats [$];
  logic [DW:0]   rq [$];
  logic [DW-1:0] wsrc [$];
  int            wpos = 0, wskip_to = 0;
  int            rd_mode = 0;
  int            dones = 0, done_errs = 0, stb_cycles = 0, b2b = 0;
  logic          prev_ack = 1'b0;

  // Stream driver and bus monitor: drive on negedge, sample 1 time unit later
  initial begin
    forever begin
      @(negedge clk);
      if (wpos < wskip_to) wpos = wskip_to;
      case (rd_mode)
        1:       rdat_ready = 1'b0;
        2:       rdat_ready = 1'b1;
        default: rdat_ready = ($urandom_range(0, 3) != 0);
      endcase
      wdat_valid = (wpos < wsrc.size()) && ($urandom_range(0, 3) != 0);
      wdat       = (wpos < wsrc.size()) ? wsrc[wpos] : '0;
      #1;
      if (rst_n) begin
        if (wdat_valid && wdat_ready) wpos++;
        if (rdat_valid && rdat_ready) rq.push_back({rdat_last, rdat});
        if (wb.cyc && wb.stb) stb_cycles++;
        if (wb.stb && prev_ack) b2b++;
        if (wb.cyc && wb.stb && (wb.ack || wb.err))
          beats.push_back('{adr: wb.adr, cti: wb.cti, err: wb.err});
        prev_ack = wb.ack;
        if (done) begin
          dones++;
          if (done_err) done_errs++;
        end
      end
    end
  end

  int            n_tests = 0, n_fail = 0;
  logic [DW-1:0] ref_mem [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
    #2;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int c = 0;
    while (dones == d0 && c < budget) begin
      tick(1);
      c++;
    end
    check("done_timeout", 64'(dones != d0), 64'd1);
  endtask

  // One command: rd_stall 0=random ready, 1=ready low 10 cycles first, 2=ready high
  task automatic do_cmd(input logic we, input logic [AW-1:0] adr, input int len, input logic [3:0] sel,
                        input int err_rel, input int rd_stall, input bit fixed);
    int            n, nacc, nbus, bb, rb, d0, de0, s0, b0, wbase;
    logic [DW-1:0] wd [$];
    logic [AW-1:0] a;
    logic [2:0]    ecti;
    n     = (len > MAXLEN) ? MAXLEN : len;
    nbus  = (err_rel > 0) ? err_rel : n;
    nacc  = (err_rel > 0) ? err_rel - 1 : n;
    wbase = wsrc.size();
    wskip_to = wbase;
    if (we)
      for (int i = 0; i < n; i++) begin
        wd.push_back(fixed ? DW'(32'hA0 + i) : DW'($urandom));
        wsrc.push_back(wd[i]);
      end
    bb  = beats.size();
    rb  = rq.size();
    d0  = dones;
    de0 = done_errs;
    b0  = b2b;
    err_at  = (err_rel > 0) ? slv_beats + err_rel - 1 : -1;
    rd_mode = (rd_stall == 1) ? 1 : rd_stall;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = LW'(len); cmd_sel = sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (rd_stall == 1) begin
      tick(10);
      check("stall_beats", 64'(beats.size() - bb), 64'd2);
      check("stall_stb", 64'(wb.stb), 64'd0);
      check("stall_rvalid", 64'(rdat_valid), 64'd1);
      rd_mode = 2;
    end
    wait_done(d0, 400);
    s0 = stb_cycles;
    tick(8);
    check("stb_after_done", 64'(stb_cycles - s0), 64'd0);
    check("done_count", 64'(dones - d0), 64'd1);
    check("done_err", 64'(done_errs - de0), 64'(err_rel > 0));
    check("beat_count", 64'(beats.size() - bb), 64'(nbus));
    check("wdat_taken", 64'(wpos - wbase), we ? 64'(nbus) : 64'd0);
`ifndef PERIPHERAL_SPRAM_WB_MASTER_BURST_EN
    check("stb_gap", 64'(b2b - b0), 64'd0);
`endif
    for (int i = 0; i < nbus && bb + i < beats.size(); i++) begin
      a = adr + AW'(i);
`ifdef PERIPHERAL_SPRAM_WB_MASTER_BURST_EN
      ecti = (i == n - 1) ? 3'b111 : 3'b010;
`else
      ecti = 3'b000;
`endif
      check("beat_adr", 64'(beats[bb+i].adr), 64'(a));
      check("beat_cti", 64'(beats[bb+i].cti), 64'(ecti));
      check("beat_err", 64'(beats[bb+i].err), 64'((err_rel > 0) && (i == nbus - 1)));
    end
    if (we) begin
      for (int i = 0; i < nacc; i++) begin
        a = adr + AW'(i);
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[a][8*b +: 8] = wd[i][8*b +: 8];
      end
    end else begin
      check("rdat_count", 64'(rq.size() - rb), 64'(nacc));
      for (int i = 0; i < nacc && rb + i < rq.size(); i++) begin
        a = adr + AW'(i);
        check("rdat_data", 64'(rq[rb+i][DW-1:0]), 64'(ref_mem[a]));
        check("rdat_last", 64'(rq[rb+i][DW]), 64'((err_rel == 0) && (i == n - 1)));
      end
    end
    err_at  = -1;
    rd_mode = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int mism;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    #3;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_ctrl", 64'({wdat_ready, rdat_valid, rdat_last, done, done_err, wb.cyc, wb.stb, wb.we}), 64'd0);
    check("rst_bus", 64'({wb.adr, wb.sel, wb.bte, wb.cti}), 64'd0);
    check("rst_data", {rdat, wb.dat_w}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    mism = stb_cycles;
    tick(20);
    check("idle_no_stb", 64'(stb_cycles - mism), 64'd0);
    check("idle_no_done", 64'(dones), 64'd0);

    do_cmd(1'b1, 8'h10, 4, 4'hF, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) check("wr_mem", 64'(smem[8'h10 + i]), 64'(32'hA0 + i));
    do_cmd(1'b0, 8'h10, 4, 4'h0, 0, 2, 1'b0);
    do_cmd(1'b0, 8'h10, 6, 4'h0, 0, 1, 1'b0);
    do_cmd(1'b1, 8'hFE, MAXLEN + 3, 4'hF, 0, 0, 1'b0);
    do_cmd(1'b0, 8'hFE, MAXLEN + 3, 4'h0, 0, 0, 1'b0);
    do_cmd(1'b1, 8'h30, 5, 4'hF, 2, 0, 1'b0);
    do_cmd(1'b0, 8'h30, 3, 4'h0, 2, 0, 1'b0);
    do_cmd(1'b1, 8'h00, 0, 4'hF, 0, 0, 1'b0);
    do_cmd(1'b1, 8'h50, 4, 4'b0101, 0, 0, 1'b0);
    do_cmd(1'b0, 8'h50, 4, 4'h0, 0, 0, 1'b0);

    for (int k = 0; k < 12; k++)
      do_cmd(1'($urandom_range(0, 1)), AW'($urandom), $urandom_range(0, MAXLEN + 3),
             4'($urandom), 0, 0, 1'b0);

    // Reset in the middle of a stalled read burst
    rd_mode = 1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 8'h40; cmd_len = LW'(8); cmd_sel = 4'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    tick(10);
    check("prerst_rvalid", 64'(rdat_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_cyc_stb", 64'({wb.cyc, wb.stb}), 64'd0);
    check("midrst_rvalid", 64'(rdat_valid), 64'd0);
    check("midrst_ready", 64'(cmd_ready), 64'd1);
    tick(2);
    rd_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    do_cmd(1'b0, 8'h40, 8, 4'h0, 0, 0, 1'b0);

    mism = 0;
    for (int i = 0; i < 256; i++) if (smem[i] !== ref_mem[i]) mism++;
    check("mem_image", 64'(mism), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
